// File: rtl/mu0_reg_mode_if.sv
// Operation/data bundle for the mode-controlled MU0 register.
// The master drives the operation; the register (slave) returns Q and its flags.
interface mu0_reg_mode_if #(
  parameter int WIDTH = 12
) ();
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             zero;

  modport master (output en, mode, d, ser_in, input q, carry, zero);
  modport slave  (input en, mode, d, ser_in, output q, carry, zero);
endinterface

// File: rtl/mu0_reg_mode.sv
// Parametrised MU0 datapath register with load, inc/dec, shift, rotate and clear,
// a registered carry/borrow/shift-out flag and a combinational zero flag.
module mu0_reg_mode #(
  parameter int          WIDTH     = 12,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mu0_reg_mode_if.slave  bus
);
  localparam logic [WIDTH-1:0] LP_RST = RESET_VAL[WIDTH-1:0];

  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_INC  = 3'b010;
  localparam logic [2:0] MODE_DEC  = 3'b011;
  localparam logic [2:0] MODE_SHL  = 3'b100;
  localparam logic [2:0] MODE_SHR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH:0]   w_inc;

  // Increment is done one bit wider so the top bit becomes the carry.
  assign w_inc = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q     <= LP_RST;
      r_carry <= 1'b0;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_LOAD: begin
          r_q     <= bus.d;
          r_carry <= 1'b0;
        end
        MODE_INC: begin
          r_q     <= w_inc[WIDTH-1:0];
          r_carry <= w_inc[WIDTH];
        end
        MODE_DEC: begin
          r_q     <= r_q - {{(WIDTH-1){1'b0}}, 1'b1};
          r_carry <= (r_q == '0);
        end
        MODE_SHL: begin
          r_q     <= {r_q[WIDTH-2:0], bus.ser_in};
          r_carry <= r_q[WIDTH-1];
        end
        MODE_SHR: begin
          r_q     <= {bus.ser_in, r_q[WIDTH-1:1]};
          r_carry <= r_q[0];
        end
        MODE_ROL: begin
          r_q     <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          r_carry <= r_q[WIDTH-1];
        end
        MODE_CLR: begin
          r_q     <= '0;
          r_carry <= 1'b0;
        end
        default: begin
          r_q     <= r_q;
          r_carry <= r_carry;
        end
      endcase
    end
  end

  assign bus.q     = r_q;
  assign bus.carry = r_carry;
  assign bus.zero  = (r_q == '0);
endmodule
